// File: rtl/branch_alu_rs_if.sv
// Branch reservation station bus.
// Groups dispatch, CDB snoop, the issue port to the branch CDB stage and the
// entry-release handshake.
//   master: producer side (dispatch, CDB, finish driver; issue consumer)
//   slave : reservation station side
interface branch_alu_rs_if #(
    parameter int RS_IDX_W = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 4
);
    logic                dispatch_valid;
    logic [2:0]          dispatch_op;
    logic                dispatch_a_rdy;
    logic [DATA_W-1:0]   dispatch_a;
    logic [TAG_W-1:0]    dispatch_a_tag;
    logic                dispatch_b_rdy;
    logic [DATA_W-1:0]   dispatch_b;
    logic [TAG_W-1:0]    dispatch_b_tag;
    logic [ADDR_W-1:0]   dispatch_offset;
    logic                rs_full;

    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;

    logic                branch_signal;
    logic [RS_IDX_W-1:0] branch_rs_num;
    logic                branch_result;
    logic [ADDR_W-1:0]   branch_offset;

    logic                branch_finish;
    logic [RS_IDX_W-1:0] finish_rs_num;

    modport slave (
        input  dispatch_valid, dispatch_op,
               dispatch_a_rdy, dispatch_a, dispatch_a_tag,
               dispatch_b_rdy, dispatch_b, dispatch_b_tag,
               dispatch_offset,
               cdb_valid, cdb_tag, cdb_data,
               branch_finish, finish_rs_num,
        output rs_full, branch_signal, branch_rs_num, branch_result, branch_offset
    );

    modport master (
        output dispatch_valid, dispatch_op,
               dispatch_a_rdy, dispatch_a, dispatch_a_tag,
               dispatch_b_rdy, dispatch_b, dispatch_b_tag,
               dispatch_offset,
               cdb_valid, cdb_tag, cdb_data,
               branch_finish, finish_rs_num,
        input  rs_full, branch_signal, branch_rs_num, branch_result, branch_offset
    );
endinterface

// File: rtl/branch_alu_rs.sv
// Branch ALU reservation station.
// Holds RS_DEPTH pending conditional branches, snoops the CDB for missing
// operands, issues the lowest-index ready entry one per cycle with its compare
// outcome and stored offset, and frees entries on the finish handshake.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - branch_alu_rs_if.slave (dispatch, rs_full, CDB snoop, issue, finish)
module branch_alu_rs #(
    parameter int RS_DEPTH = 4,
    parameter int RS_IDX_W = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 4
) (
    input logic             clk,
    input logic             rst,
    branch_alu_rs_if.slave  bus
);

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              a_rdy;
        logic              b_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [TAG_W-1:0]  b_tag;
        logic [ADDR_W-1:0] off;
    } entry_t;

    logic [RS_DEPTH-1:0] r_busy;
    logic [RS_DEPTH-1:0] r_issued;
    entry_t              r_ent [RS_DEPTH];

    logic                r_sig;
    logic [RS_IDX_W-1:0] r_num;
    logic                r_res;
    logic [ADDR_W-1:0]   r_off;

    logic                w_full;
    logic [RS_IDX_W-1:0] w_free_idx;
    logic                w_iss_found;
    logic [RS_IDX_W-1:0] w_iss_idx;

    function automatic logic br_cmp(input logic [2:0] op,
                                    input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Free slot and issue pick both look only at pre-edge state, so an entry
    // released or woken this cycle is not reused/issued until the next one.
    // Descending scan makes the lowest index win.
    always_comb begin
        w_full      = &r_busy;
        w_free_idx  = '0;
        w_iss_found = 1'b0;
        w_iss_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i])
                w_free_idx = RS_IDX_W'(i);
            if (r_busy[i] && !r_issued[i] && r_ent[i].a_rdy && r_ent[i].b_rdy) begin
                w_iss_found = 1'b1;
                w_iss_idx   = RS_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy   <= '0;
            r_issued <= '0;
            for (int i = 0; i < RS_DEPTH; i++)
                r_ent[i] <= '0;
            r_sig <= 1'b0;
            r_num <= '0;
            r_res <= 1'b0;
            r_off <= '0;
        end else begin
            // Wakeup of waiting operands in busy entries.
            if (bus.cdb_valid) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (r_busy[i] && !r_ent[i].a_rdy && r_ent[i].a_tag == bus.cdb_tag) begin
                        r_ent[i].a     <= bus.cdb_data;
                        r_ent[i].a_rdy <= 1'b1;
                    end
                    if (r_busy[i] && !r_ent[i].b_rdy && r_ent[i].b_tag == bus.cdb_tag) begin
                        r_ent[i].b     <= bus.cdb_data;
                        r_ent[i].b_rdy <= 1'b1;
                    end
                end
            end

            // Issue: one-cycle pulse, zeros when nothing is eligible.
            r_sig <= w_iss_found;
            if (w_iss_found) begin
                r_num <= w_iss_idx;
                r_res <= br_cmp(r_ent[w_iss_idx].op, r_ent[w_iss_idx].a, r_ent[w_iss_idx].b);
                r_off <= r_ent[w_iss_idx].off;
                r_issued[w_iss_idx] <= 1'b1;
            end else begin
                r_num <= '0;
                r_res <= 1'b0;
                r_off <= '0;
            end

            // Release only touches busy entries; dispatch only non-busy ones.
            if (bus.branch_finish && r_busy[bus.finish_rs_num]) begin
                r_busy[bus.finish_rs_num]   <= 1'b0;
                r_issued[bus.finish_rs_num] <= 1'b0;
            end

            if (bus.dispatch_valid && !w_full) begin
                r_busy[w_free_idx]       <= 1'b1;
                r_issued[w_free_idx]     <= 1'b0;
                r_ent[w_free_idx].op     <= bus.dispatch_op;
                r_ent[w_free_idx].off    <= bus.dispatch_offset;
                r_ent[w_free_idx].a_tag  <= bus.dispatch_a_tag;
                r_ent[w_free_idx].b_tag  <= bus.dispatch_b_tag;
                // A producer broadcasting in the dispatch cycle would otherwise
                // be missed, since wakeup only scans already-busy entries.
                if (bus.dispatch_a_rdy) begin
                    r_ent[w_free_idx].a     <= bus.dispatch_a;
                    r_ent[w_free_idx].a_rdy <= 1'b1;
                end else if (bus.cdb_valid && bus.cdb_tag == bus.dispatch_a_tag) begin
                    r_ent[w_free_idx].a     <= bus.cdb_data;
                    r_ent[w_free_idx].a_rdy <= 1'b1;
                end else begin
                    r_ent[w_free_idx].a     <= '0;
                    r_ent[w_free_idx].a_rdy <= 1'b0;
                end
                if (bus.dispatch_b_rdy) begin
                    r_ent[w_free_idx].b     <= bus.dispatch_b;
                    r_ent[w_free_idx].b_rdy <= 1'b1;
                end else if (bus.cdb_valid && bus.cdb_tag == bus.dispatch_b_tag) begin
                    r_ent[w_free_idx].b     <= bus.cdb_data;
                    r_ent[w_free_idx].b_rdy <= 1'b1;
                end else begin
                    r_ent[w_free_idx].b     <= '0;
                    r_ent[w_free_idx].b_rdy <= 1'b0;
                end
            end
        end
    end

    assign bus.rs_full       = w_full;
    assign bus.branch_signal = r_sig;
    assign bus.branch_rs_num = r_num;
    assign bus.branch_result = r_res;
    assign bus.branch_offset = r_off;

endmodule

// File: tb/tb_branch_alu_rs.sv
// Self-checking bench for branch_alu_rs: a table of single-branch compare
// vectors plus directed sequences for wakeup, fill/release, ordering and reset.
module tb_branch_alu_rs;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_alu_rs_if bus ();

    branch_alu_rs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] off;
        logic        res;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic sig, input logic [1:0] num,
                           input logic res, input logic [31:0] off);
        chk({nm, ".signal"}, 64'(bus.branch_signal), 64'(sig));
        chk({nm, ".rs_num"}, 64'(bus.branch_rs_num), 64'(num));
        chk({nm, ".result"}, 64'(bus.branch_result), 64'(res));
        chk({nm, ".offset"}, 64'(bus.branch_offset), 64'(off));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        bus.branch_finish  = 1'b0;
    endtask

    task automatic disp(input logic [2:0] op,
                        input logic a_rdy, input logic [31:0] a, input logic [3:0] a_tag,
                        input logic b_rdy, input logic [31:0] b, input logic [3:0] b_tag,
                        input logic [31:0] off);
        bus.dispatch_valid  = 1'b1;
        bus.dispatch_op     = op;
        bus.dispatch_a_rdy  = a_rdy;
        bus.dispatch_a      = a;
        bus.dispatch_a_tag  = a_tag;
        bus.dispatch_b_rdy  = b_rdy;
        bus.dispatch_b      = b;
        bus.dispatch_b_tag  = b_tag;
        bus.dispatch_offset = off;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    task automatic finish(input logic [1:0] n);
        bus.branch_finish = 1'b1;
        bus.finish_rs_num = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        vt[0]  = '{"beq_eq",    3'b000, 32'd5,        32'd5, 32'h10, 1'b1};
        vt[1]  = '{"bne_eq",    3'b001, 32'd5,        32'd5, 32'h20, 1'b0};
        vt[2]  = '{"bne_ne",    3'b001, 32'd1,        32'd2, 32'h24, 1'b1};
        vt[3]  = '{"op010",     3'b010, 32'd7,        32'd7, 32'h30, 1'b0};
        vt[4]  = '{"op011",     3'b011, 32'd7,        32'd8, 32'h34, 1'b0};
        vt[5]  = '{"blt_neg",   3'b100, 32'hFFFFFFFF, 32'd0, 32'h40, 1'b1};
        vt[6]  = '{"bge_neg",   3'b101, 32'hFFFFFFFF, 32'd0, 32'h44, 1'b0};
        vt[7]  = '{"bltu_big",  3'b110, 32'hFFFFFFFF, 32'd0, 32'h48, 1'b0};
        vt[8]  = '{"bgeu_big",  3'b111, 32'hFFFFFFFF, 32'd0, 32'h4C, 1'b1};
        vt[9]  = '{"blt_equal", 3'b100, 32'd3,        32'd3, 32'h50, 1'b0};
        vt[10] = '{"bge_equal", 3'b101, 32'd3,        32'd3, 32'h54, 1'b1};
        vt[11] = '{"bltu_lt",   3'b110, 32'd1,        32'd2, 32'hDEADBEE0, 1'b1};

        rst = 1'b0;
        idle();
        bus.dispatch_op = '0;    bus.dispatch_a_rdy = 1'b0; bus.dispatch_a = '0;
        bus.dispatch_a_tag = '0; bus.dispatch_b_rdy = 1'b0; bus.dispatch_b = '0;
        bus.dispatch_b_tag = '0; bus.dispatch_offset = '0;
        bus.cdb_tag = '0; bus.cdb_data = '0; bus.finish_rs_num = '0;
        #2;
        chk_out("reset", 1'b0, 2'd0, 1'b0, 32'h0);
        chk("reset.rs_full", 64'(bus.rs_full), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Table: dispatch both-ready, issue next edge for one cycle, release.
        for (int i = 0; i < 12; i++) begin
            disp(vt[i].op, 1'b1, vt[i].a, 4'd0, 1'b1, vt[i].b, 4'd0, vt[i].off);
            tick();
            idle();
            chk({vt[i].name, ".pre"}, 64'(bus.branch_signal), 64'd0);
            tick();
            chk_out(vt[i].name, 1'b1, 2'd0, vt[i].res, vt[i].off);
            finish(2'd0);
            tick();
            idle();
            chk_out({vt[i].name, ".after"}, 1'b0, 2'd0, 1'b0, 32'h0);
        end

        // Late operand: BLT then BLTU, B arrives on CDB two cycles later.
        for (int k = 0; k < 2; k++) begin
            disp(k == 0 ? 3'b100 : 3'b110, 1'b1, 32'hFFFFFFFF, 4'd0, 1'b0, 32'h0, 4'd3, 32'h60);
            tick();
            idle();
            tick();
            chk("wake.wait", 64'(bus.branch_signal), 64'd0);
            cdb(4'd3, 32'd0);
            tick();
            idle();
            chk("wake.edge", 64'(bus.branch_signal), 64'd0);
            tick();
            chk_out(k == 0 ? "wake.blt" : "wake.bltu", 1'b1, 2'd0, k == 0, 32'h60);
            finish(2'd0);
            tick();
            idle();
        end

        // Same-cycle CDB capture at dispatch.
        disp(3'b000, 1'b1, 32'd9, 4'd0, 1'b0, 32'h0, 4'd7, 32'h70);
        cdb(4'd7, 32'd9);
        tick();
        idle();
        tick();
        chk_out("dispcdb", 1'b1, 2'd0, 1'b1, 32'h70);
        finish(2'd0);
        tick();
        idle();

        // Fill all four with waiting entries.
        disp(3'b000, 1'b1, 32'd6, 4'd0, 1'b0, 32'h0, 4'd5, 32'h100); tick();
        disp(3'b000, 1'b1, 32'd6, 4'd0, 1'b0, 32'h0, 4'd6, 32'h101); tick();
        disp(3'b000, 1'b1, 32'd6, 4'd0, 1'b0, 32'h0, 4'd5, 32'h102); tick();
        chk("fill.3", 64'(bus.rs_full), 64'd0);
        disp(3'b001, 1'b1, 32'd6, 4'd0, 1'b0, 32'h0, 4'd6, 32'h103); tick();
        chk("fill.4", 64'(bus.rs_full), 64'd1);
        disp(3'b000, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'h999); tick();
        idle();
        chk("full.ignored", 64'(bus.branch_signal), 64'd0);
        tick();
        chk("full.ignored2", 64'(bus.branch_signal), 64'd0);
        finish(2'd2);
        tick();
        idle();
        chk("free2.rs_full", 64'(bus.rs_full), 64'd0);
        disp(3'b000, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 32'h222);
        tick();
        idle();
        chk("refill.rs_full", 64'(bus.rs_full), 64'd1);
        tick();
        chk_out("refill.issue", 1'b1, 2'd2, 1'b1, 32'h222);

        // Entries 1 and 3 wake together; lower index first.
        cdb(4'd6, 32'd6);
        tick();
        idle();
        chk("order.wake", 64'(bus.branch_signal), 64'd0);
        tick();
        chk_out("order.first", 1'b1, 2'd1, 1'b1, 32'h101);
        tick();
        chk_out("order.second", 1'b1, 2'd3, 1'b0, 32'h103);
        tick();
        chk_out("order.none", 1'b0, 2'd0, 1'b0, 32'h0);

        // Reset while an entry is issued.
        cdb(4'd5, 32'd7);
        tick();
        idle();
        tick();
        chk_out("rst.pre", 1'b1, 2'd0, 1'b0, 32'h100);
        rst = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 2'd0, 1'b0, 32'h0);
        chk("rst.rs_full", 64'(bus.rs_full), 64'd0);
        @(negedge clk) rst = 1'b1;
        cdb(4'd5, 32'd7);
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            chk("rst.quiet", 64'(bus.branch_signal), 64'd0);
            tick();
        end
        disp(3'b000, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0, 32'h300);
        tick();
        idle();
        tick();
        chk_out("rst.newdisp", 1'b1, 2'd0, 1'b1, 32'h300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_alu_rs.md
BRANCH_ALU_RS -- requirements
Module: branch_alu_rs

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, meaning number of reservation-station entries.
REQ-002 SHALL have parameter RS_IDX_W, default 2, meaning entry index width (log2 RS_DEPTH).
REQ-003 SHALL have parameter DATA_W, default 32, meaning operand width; ADDR_W, default 32, meaning offset width; TAG_W, default 4, meaning rename tag width.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: dispatch_valid in 1 new branch; dispatch_op in 3 compare code; dispatch_a_rdy in 1, dispatch_a in DATA_W, dispatch_a_tag in TAG_W (operand A value or tag); dispatch_b_rdy, dispatch_b, dispatch_b_tag likewise; dispatch_offset in ADDR_W taken-offset; rs_full out 1.
REQ-006 SHALL have ports: cdb_valid in 1, cdb_tag in TAG_W, cdb_data in DATA_W, the result-broadcast snoop.
REQ-007 SHALL have ports: branch_signal out 1, branch_rs_num out RS_IDX_W, branch_result out 1 (taken), branch_offset out ADDR_W, all to the branch CDB stage.
REQ-008 SHALL have ports: branch_finish in 1 and finish_rs_num in RS_IDX_W, the entry-release handshake from the branch CDB stage.

Function
REQ-009 Each entry SHALL hold: busy, issued, op, A/B value, A/B ready, A/B tag, offset.
REQ-010 rs_full SHALL be combinational: 1 when every entry is busy, issued or not.
REQ-011 When dispatch_valid=1 and rs_full=0, the lowest-index non-busy entry SHALL be written at the clock edge with busy=1, issued=0; dispatch_valid while rs_full=1 SHALL be ignored.
REQ-012 Operand capture at dispatch: if rdy=1, store value, ready=1; else if cdb_valid and cdb_tag equals operand tag in the same cycle, store cdb_data, ready=1; else store tag, ready=0.
REQ-013 Wakeup: every busy entry with a non-ready operand whose tag equals cdb_tag while cdb_valid=1 SHALL capture cdb_data and set ready at that edge; both operands may wake in one cycle.
REQ-014 Selection SHALL use registered state only: eligible = busy and not issued and A ready and B ready; the lowest-index eligible entry is chosen.
REQ-015 If an entry is eligible at edge N, then branch_signal=1 with branch_rs_num, branch_result and branch_offset SHALL be registered at edge N and held for exactly one cycle; that entry's issued bit SHALL be set at the same edge.
REQ-016 With no eligible entry, branch_signal, branch_rs_num, branch_result and branch_offset SHALL all be 0.
REQ-017 At most one issue per cycle; an entry woken at edge N SHALL issue no earlier than edge N+1.
REQ-018 branch_result SHALL be: op 000 A==B; 001 A!=B; 100 signed A<B; 101 signed A>=B; 110 unsigned A<B; 111 unsigned A>=B; 010 and 011 give 0.
REQ-019 branch_offset SHALL carry the stored offset unmodified; taken/not-taken offset selection is done downstream.
REQ-020 branch_finish=1 SHALL clear busy and issued of entry finish_rs_num at the edge; a finish naming a non-busy entry SHALL be ignored.
REQ-021 An entry freed at edge N SHALL NOT be the dispatch target at edge N; free/full SHALL be computed from pre-edge busy bits.
REQ-022 Dispatch, wakeup, issue and finish in one cycle SHALL act on distinct state without conflict.

Reset
REQ-023 rst=0 SHALL immediately clear all busy, issued and ready bits and drive branch_signal, branch_rs_num, branch_result, branch_offset to 0; rs_full then reads 0.
REQ-024 Reset mid-operation SHALL discard all entries, including issued-but-unfinished ones, with no further output until new dispatches.

Verification
REQ-025 Dispatch BEQ with A=5 and B=5, both ready, offset 0x10 -> next edge: branch_signal=1, rs_num=0, result=1, offset=0x10, asserted one cycle.
REQ-026 Dispatch BLT with A=0xFFFFFFFF ready and B tag 3 not ready; CDB tag 3 data 0 two cycles later -> issue one edge after wakeup, result=1 (signed -1<0); the same case with BLTU gives result=0.
REQ-027 Four dispatches with no finishes -> rs_full=1, and a fifth dispatch is ignored; branch_finish on rs_num 2 -> rs_full=0 next cycle, and the next dispatch lands in entry 2.
REQ-028 Dispatch with B tag 7 in the same cycle as cdb_valid with tag 7 and data 9 -> B captured as 9, entry issues next edge.
REQ-029 Entries 1 and 3 become eligible at the same edge -> entry 1 issues first, entry 3 on the following edge.
REQ-030 Assert rst=0 while an entry is issued -> outputs 0 immediately, and no issue occurs after rst=1 until a new dispatch.
